// File: rtl/relu_maxpool_2x2.sv
`default_nettype none
// ============================================================================
// Module   : relu_maxpool_2x2
// Brief    : ReLU followed by 2x2/stride-2 max pooling on a raster pixel
//            stream, using a half-row partial-max buffer for full-rate input.
// Revision : 1.0 - initial release
// ============================================================================
module relu_maxpool_2x2 #(
    parameter int DATA_W = 16,
    parameter int FMAP_W = 4,
    parameter int FMAP_H = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              frame_done,
    input  logic              err_clr,
    output logic [DATA_W-1:0] pool_out,
    output logic              pool_valid,
    output logic              pool_done,
    output logic              frame_err
);

    localparam int c_COL_W    = $clog2(FMAP_W);
    localparam int c_ROW_W    = $clog2(FMAP_H);
    localparam int c_IDX_W    = (FMAP_W > 2) ? $clog2(FMAP_W / 2) : 1;
    localparam int c_LBUF_N   = 1 << c_IDX_W;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(FMAP_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(FMAP_H - 1);

    localparam logic [0:0] c_EVEN_ROW = 1'b0;
    localparam logic [0:0] c_ODD_ROW  = 1'b1;

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [0:0]         r_phase;
    logic [DATA_W-1:0]  r_hold;
    logic [DATA_W-1:0]  r_lbuf [0:c_LBUF_N-1];

    logic [DATA_W-1:0]  w_relu;
    logic [c_IDX_W-1:0] w_idx;
    logic [DATA_W-1:0]  w_max_hold;
    logic [DATA_W-1:0]  w_max_lbuf;
    logic               w_last_col;
    logic               w_last_row;
    logic [c_COL_W-1:0] w_col_nxt;
    logic [c_ROW_W-1:0] w_row_nxt;
    logic               w_err;
    logic               w_fire;

    function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // After ReLU every value is non-negative, so unsigned compares are exact.
    assign w_relu     = din[DATA_W-1] ? '0 : din;
    assign w_idx      = c_IDX_W'(r_col >> 1);
    assign w_max_hold = f_max(r_hold, w_relu);
    assign w_max_lbuf = f_max(r_lbuf[w_idx], w_relu);
    assign w_last_col = (r_col == c_COL_LAST);
    assign w_last_row = (r_row == c_ROW_LAST);

    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (din_valid) begin
            w_col_nxt = w_last_col ? '0 : r_col + 1'b1;
            if (w_last_col) begin
                w_row_nxt = w_last_row ? '0 : r_row + 1'b1;
            end
        end
    end

    // The frame_done check sees the counters after this cycle's pixel.
    assign w_err  = frame_done && ((w_col_nxt != '0) || (w_row_nxt != '0));
    assign w_fire = din_valid && (r_phase == c_ODD_ROW) && r_col[0] && !w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_phase    <= c_EVEN_ROW;
            r_hold     <= '0;
            pool_out   <= '0;
            pool_valid <= 1'b0;
            pool_done  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            pool_valid <= w_fire;
            pool_done  <= w_fire && w_last_row && w_last_col;
            if (w_fire) begin
                pool_out <= w_max_hold;
            end
            if (din_valid && !r_col[0]) begin
                r_hold <= (r_phase == c_EVEN_ROW) ? w_relu : w_max_lbuf;
            end
            if (w_err) begin
                r_col   <= '0;
                r_row   <= '0;
                r_phase <= c_EVEN_ROW;
            end else begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                if (din_valid && w_last_col) begin
                    r_phase <= (r_phase == c_EVEN_ROW) ? c_ODD_ROW : c_EVEN_ROW;
                end
            end
            if (w_err) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

    // Partial maxima of the upper row of each window; never read before written.
    always_ff @(posedge clk) begin
        if (din_valid && (r_phase == c_EVEN_ROW) && r_col[0]) begin
            r_lbuf[w_idx] <= w_max_hold;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool_2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_maxpool_2x2
// Brief    : Scoreboard bench for relu_maxpool_2x2 with a frame-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relu_maxpool_2x2;

    localparam int DATA_W = 16;
    localparam int FMAP_W = 4;
    localparam int FMAP_H = 4;
    localparam int NPIX   = FMAP_W * FMAP_H;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] din = '0;
    logic              din_valid = 1'b0;
    logic              frame_done = 1'b0;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] pool_out;
    logic              pool_valid;
    logic              pool_done;
    logic              frame_err;

    relu_maxpool_2x2 #(.DATA_W(DATA_W), .FMAP_W(FMAP_W), .FMAP_H(FMAP_H)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_done (frame_done),
        .err_clr    (err_clr),
        .pool_out   (pool_out),
        .pool_valid (pool_valid),
        .pool_done  (pool_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit done;
        int stamp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model state: a whole frame of ReLU'd pixels plus raster position.
    int   m_pix [0:FMAP_H-1][0:FMAP_W-1];
    int   m_col = 0;
    int   m_row = 0;
    bit   m_err = 1'b0;
    logic [DATA_W-1:0] fr [0:NPIX-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && pool_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0d expected none (cycle %0d)",
                         pool_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_int("pool_out", int'(pool_out), e.data);
                check_int("pool_done", int'(pool_done), int'(e.done));
                check_int("latency_cycle", cyc, e.stamp);
            end
        end else if (!rst && pool_done) begin
            check_int("pool_done_without_valid", int'(pool_done), 0);
        end
    end

    function automatic int relu(input logic [DATA_W-1:0] d);
        int s;
        s = int'($signed(d));
        return (s < 0) ? 0 : s;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic drive(input bit v, input logic [DATA_W-1:0] d, input bit fd,
                         input bit clr);
        bit pushed;
        @(negedge clk);
        check_int("frame_err", int'(frame_err), int'(m_err));
        din_valid  = v;
        din        = d;
        frame_done = fd;
        err_clr    = clr;
        pushed     = 1'b0;
        if (v) begin
            m_pix[m_row][m_col] = relu(d);
            if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
                exp_t e;
                e.data  = max4(m_pix[m_row-1][m_col-1], m_pix[m_row-1][m_col],
                               m_pix[m_row][m_col-1],   m_pix[m_row][m_col]);
                e.done  = (m_row == FMAP_H - 1) && (m_col == FMAP_W - 1);
                e.stamp = cyc + 1;
                exp_q.push_back(e);
                pushed = 1'b1;
            end
            m_col++;
            if (m_col == FMAP_W) begin
                m_col = 0;
                m_row = (m_row + 1) % FMAP_H;
            end
        end
        if (fd && (m_col != 0 || m_row != 0)) begin
            if (pushed) void'(exp_q.pop_back());
            m_col = 0;
            m_row = 0;
            m_err = 1'b1;
        end else if (clr) begin
            m_err = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    // npix pixels of fr[], random gaps up to gap_max; trailer: 0 none,
    // 1 frame_done on the last pixel, 2 frame_done one cycle after.
    task automatic send_frame(input int npix, input int gap_max, input int trailer);
        for (int i = 0; i < npix; i++) begin
            idle($urandom_range(0, gap_max));
            drive(1'b1, fr[i], (trailer == 1) && (i == npix - 1), 1'b0);
        end
        if (trailer == 2) drive(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst        = 1'b1;
        din_valid  = 1'b0;
        frame_done = 1'b0;
        err_clr    = 1'b0;
        #1;
        check_int("rst_pool_out", int'(pool_out), 0);
        check_int("rst_pool_valid", int'(pool_valid), 0);
        check_int("rst_pool_done", int'(pool_done), 0);
        check_int("rst_frame_err", int'(frame_err), 0);
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < NPIX; i++) fr[i] = DATA_W'(i + 1);
    endtask

    initial begin
        #1;
        check_int("init_pool_out", int'(pool_out), 0);
        check_int("init_pool_valid", int'(pool_valid), 0);
        check_int("init_frame_err", int'(frame_err), 0);
        do_reset();

        // Ramp frame, continuous input.
        load_ramp();
        send_frame(NPIX, 0, 2);
        idle(3);

        // ReLU: all -5 except a 3 at (1,1); then all negative.
        for (int i = 0; i < NPIX; i++) fr[i] = 16'hFFFB;
        fr[FMAP_W + 1] = 16'h0003;
        send_frame(NPIX, 0, 1);
        for (int i = 0; i < NPIX; i++) fr[i] = 16'h8000 | DATA_W'($urandom);
        send_frame(NPIX, 1, 2);
        idle(2);

        // Bursty ramp, then two back-to-back frames with frame_done on last pixel.
        load_ramp();
        send_frame(NPIX, 3, 2);
        send_frame(NPIX, 0, 1);
        send_frame(NPIX, 0, 1);
        idle(2);

        // Early frame_done, recovery frame, then clear.
        send_frame(7, 0, 2);
        send_frame(NPIX, 0, 1);
        idle(2);
        drive(1'b0, '0, 1'b0, 1'b1);
        idle(2);

        // Error set and clear in the same cycle: set wins.
        send_frame(3, 0, 0);
        drive(1'b0, '0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        idle(2);

        // Reset mid-frame, then a full frame.
        send_frame(10, 0, 0);
        do_reset();
        send_frame(NPIX, 1, 2);
        idle(2);

        // Extreme values.
        for (int i = 0; i < NPIX; i++) fr[i] = 16'h8000;
        fr[0]          = 16'h7FFF;
        fr[FMAP_W + 1] = 16'h7FFF;
        fr[2 * FMAP_W] = 16'h7FFF;
        send_frame(NPIX, 0, 1);
        idle(2);

        // Random frames with random gaps.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NPIX; i++) fr[i] = DATA_W'($urandom);
            send_frame(NPIX, f % 3, 1 + (f % 2));
        end
        idle(4);

        check_int("pending_expected", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
